// File: rtl/booth_mul_arbiter_if.sv
// -----------------------------------------------------------------------------
// booth_mul_arbiter_if
// Bus bundle between the requesters, the shared 8x8 signed Booth multiplier and
// booth_mul_arbiter.
//   slave  : arbiter view (requests/multiplier results in, grants/responses out)
//   master : environment view (requesters + multiplier)
// Signals:
//   req_valid/req_ready           per-requester request handshake (one-hot ready)
//   req_multiplicand/multiplier   packed signed operands, slice i = [8*i+7:8*i]
//   rsp_valid/rsp_result/rsp_id   one-cycle response pulse to the winning requester
//   mul_req_valid, mul_multiplicand, mul_multiplier   issue side of the multiplier
//   mul_busy, mul_rsp_valid, mul_rsp_result           result side of the multiplier
//   busy                          arbiter not idle
// -----------------------------------------------------------------------------
interface booth_mul_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic        [NUM_REQ-1:0]   req_valid;
    logic        [NUM_REQ*8-1:0] req_multiplicand;
    logic        [NUM_REQ*8-1:0] req_multiplier;
    logic        [NUM_REQ-1:0]   req_ready;
    logic        [NUM_REQ-1:0]   rsp_valid;
    logic signed [15:0]          rsp_result;
    logic        [ID_W-1:0]      rsp_id;
    logic                        mul_req_valid;
    logic signed [7:0]           mul_multiplicand;
    logic signed [7:0]           mul_multiplier;
    logic                        mul_busy;
    logic                        mul_rsp_valid;
    logic signed [15:0]          mul_rsp_result;
    logic                        busy;

    modport slave (
        input  req_valid, req_multiplicand, req_multiplier,
        input  mul_busy, mul_rsp_valid, mul_rsp_result,
        output req_ready, rsp_valid, rsp_result, rsp_id,
        output mul_req_valid, mul_multiplicand, mul_multiplier, busy
    );

    modport master (
        output req_valid, req_multiplicand, req_multiplier,
        output mul_busy, mul_rsp_valid, mul_rsp_result,
        input  req_ready, rsp_valid, rsp_result, rsp_id,
        input  mul_req_valid, mul_multiplicand, mul_multiplier, busy
    );
endinterface

// File: rtl/booth_mul_arbiter.sv
// -----------------------------------------------------------------------------
// booth_mul_arbiter
// Shares one multi-cycle 8-bit signed Booth multiplier among NUM_REQ requesters.
// Round-robin grant in IDLE, one operation in flight, result routed back to the
// winner as a one-cycle rsp_valid pulse.
// Ports:
//   clock  - single clock
//   rst    - synchronous active-high reset (aborts any operation in flight)
//   bus    - booth_mul_arbiter_if.slave, see the interface file for signals
// Optional feature (macro BOOTH_MUL_ARB_ZERO_BYPASS_EN):
//   a granted request with a zero operand is answered with 0 without issuing
//   it to the multiplier (rsp two cycles after accept).
// -----------------------------------------------------------------------------
module booth_mul_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clock,
    input  logic               rst,
    booth_mul_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t             r_state;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [ID_W-1:0]    r_id;
    logic signed [7:0]  r_op_a;
    logic signed [7:0]  r_op_b;
    logic [NUM_REQ-1:0] r_rsp_valid;
    logic signed [15:0] r_rsp_result;
    logic [ID_W-1:0]    r_rsp_id;
    logic               r_busy;
`ifdef BOOTH_MUL_ARB_ZERO_BYPASS_EN
    logic               r_bypass;
`endif

    logic               w_found_hi;
    logic               w_found_lo;
    logic [ID_W-1:0]    w_id_hi;
    logic [ID_W-1:0]    w_id_lo;
    logic [ID_W-1:0]    w_gnt_id;
    logic [NUM_REQ-1:0] w_grant;
    logic signed [7:0]  w_sel_a;
    logic signed [7:0]  w_sel_b;

    // Round-robin pick: lowest valid index at or above rr_ptr; if none, wrap to
    // the lowest valid index overall. Scanning downwards leaves the lowest hit.
    always_comb begin
        w_found_hi = 1'b0;
        w_found_lo = 1'b0;
        w_id_hi    = '0;
        w_id_lo    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                w_found_lo = 1'b1;
                w_id_lo    = ID_W'(i);
                if (ID_W'(i) >= r_rr_ptr) begin
                    w_found_hi = 1'b1;
                    w_id_hi    = ID_W'(i);
                end
            end
        end
    end

    assign w_gnt_id = w_found_hi ? w_id_hi : w_id_lo;
    assign w_grant  = w_found_lo ? (NUM_REQ'(1) << w_gnt_id) : '0;

    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt_id == ID_W'(i)) begin
                w_sel_a = bus.req_multiplicand[8*i +: 8];
                w_sel_b = bus.req_multiplier[8*i +: 8];
            end
        end
    end

    // The grant must be visible in the same IDLE cycle it is decided, and the
    // issue pulse must react to mul_busy in the ISSUE cycle, so both are
    // decoded from the registered state rather than registered themselves.
    assign bus.req_ready = (r_state == IDLE) ? w_grant : '0;
`ifdef BOOTH_MUL_ARB_ZERO_BYPASS_EN
    assign bus.mul_req_valid = (r_state == ISSUE) && !bus.mul_busy && !r_bypass;
`else
    assign bus.mul_req_valid = (r_state == ISSUE) && !bus.mul_busy;
`endif

    assign bus.mul_multiplicand = r_op_a;
    assign bus.mul_multiplier   = r_op_b;
    assign bus.rsp_valid        = r_rsp_valid;
    assign bus.rsp_result       = r_rsp_result;
    assign bus.rsp_id           = r_rsp_id;
    assign bus.busy             = r_busy;

    always_ff @(posedge clock) begin
        if (rst) begin
            r_state      <= IDLE;
            r_rr_ptr     <= '0;
            r_id         <= '0;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_rsp_valid  <= '0;
            r_rsp_result <= '0;
            r_rsp_id     <= '0;
            r_busy       <= 1'b0;
`ifdef BOOTH_MUL_ARB_ZERO_BYPASS_EN
            r_bypass     <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found_lo) begin
                        r_op_a   <= w_sel_a;
                        r_op_b   <= w_sel_b;
                        r_id     <= w_gnt_id;
                        r_busy   <= 1'b1;
                        r_state  <= ISSUE;
`ifdef BOOTH_MUL_ARB_ZERO_BYPASS_EN
                        r_bypass <= (w_sel_a == 8'sd0) || (w_sel_b == 8'sd0);
`endif
                    end
                end
                ISSUE: begin
`ifdef BOOTH_MUL_ARB_ZERO_BYPASS_EN
                    // Zero operand: answer directly, multiplier never sees it.
                    if (r_bypass) begin
                        r_rsp_valid  <= NUM_REQ'(1) << r_id;
                        r_rsp_result <= '0;
                        r_rsp_id     <= r_id;
                        r_state      <= RESP;
                    end else if (!bus.mul_busy) begin
                        r_state <= WAIT;
                    end
`else
                    if (!bus.mul_busy) begin
                        r_state <= WAIT;
                    end
`endif
                end
                WAIT: begin
                    if (bus.mul_rsp_valid) begin
                        r_rsp_valid  <= NUM_REQ'(1) << r_id;
                        r_rsp_result <= bus.mul_rsp_result;
                        r_rsp_id     <= r_id;
                        r_state      <= RESP;
                    end
                end
                RESP: begin
                    r_rsp_valid  <= '0;
                    r_rsp_result <= '0;
                    r_rsp_id     <= '0;
                    r_busy       <= 1'b0;
                    r_rr_ptr     <= (r_id == ID_W'(NUM_REQ - 1)) ? '0 : r_id + 1'b1;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
